// File: rtl/data_axi_bridge.sv
// data_axi_bridge
//   Single-beat AXI4 master for the CPU data port. Takes SRAM-style requests
//   (ren_i pulse / wen_i held level) and runs one AR+R or AW+W+B transaction
//   at a time. A one-entry pending slot holds a request that arrives while an
//   abandoned (flushed) transaction is still draining.
//
// Ports
//   clock_i, reset_i        clock, synchronous active-low reset
//   flush_i                 suppress the ok pulse of the transaction in flight
//   ren_i, wen_i, addr_i,
//   wdata_i                 CPU request
//   read_ok_o, write_ok_o,
//   rdata_o                 CPU response (registered one-cycle pulses)
//   ar*/r*/aw*/w*/b*        AXI4 master channels (bresp not consumed)
module data_axi_bridge #(
  parameter logic [3:0] AXI_ID   = 4'd1,
  parameter logic [2:0] AXI_SIZE = 3'b010
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        flush_i,
  input  logic        ren_i,
  input  logic [3:0]  wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        read_ok_o,
  output logic        write_ok_o,
  output logic [31:0] rdata_o,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic [2:0]  awsize,
  output logic        awvalid,
  input  logic        awready,
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic [2:0] {S_IDLE, S_AR, S_R, S_WR, S_B, S_DONE} state_t;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wen;
  } req_t;

  state_t state, state_nx;
  req_t   act, pend, in_req, iss_req;
  logic   pend_v, drop, aw_done, w_done;
  logic   req_seen, capture, issue, take_pend;
  logic   aw_hs, w_hs;

  // Responses are single-beat and errors still complete the access.
  logic unused_resp;
  assign unused_resp = ^{rresp, rlast};

  assign req_seen = ren_i | (|wen_i);
  // Read wins when both are asserted.
  assign in_req   = '{wr: ~ren_i, addr: addr_i, wdata: wdata_i, wen: wen_i};
  // Only requests arriving behind a flushed transaction are real new work;
  // anything else seen while busy is the in-flight request itself.
  assign capture  = (state != S_IDLE) && req_seen && !pend_v && (drop || flush_i);

  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;

  always_ff @(posedge clock_i) begin
    if (!reset_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    issue     = 1'b0;
    take_pend = 1'b0;
    iss_req   = in_req;
    case (state)
      S_IDLE: begin
        if (pend_v) begin
          issue = 1'b1; take_pend = 1'b1; iss_req = pend;
        end else if (req_seen) begin
          issue = 1'b1;
        end
      end
      S_AR:   if (arready) state_nx = S_R;
      S_R:    if (rvalid)  state_nx = S_DONE;
      S_WR:   if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = S_B;
      S_B:    if (bvalid)  state_nx = S_DONE;
      S_DONE: begin
        state_nx = S_IDLE;
        // Back-to-back issue from the slot, skipping the IDLE cycle.
        if (pend_v) begin
          issue = 1'b1; take_pend = 1'b1; iss_req = pend;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    if (issue) state_nx = iss_req.wr ? S_WR : S_AR;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      act        <= '0;
      pend       <= '0;
      pend_v     <= 1'b0;
      drop       <= 1'b0;
      aw_done    <= 1'b0;
      w_done     <= 1'b0;
      read_ok_o  <= 1'b0;
      write_ok_o <= 1'b0;
      rdata_o    <= '0;
    end else begin
      read_ok_o  <= 1'b0;
      write_ok_o <= 1'b0;

      if (issue) begin
        act     <= iss_req;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else if (state == S_WR) begin
        if (aw_hs) aw_done <= 1'b1;
        if (w_hs)  w_done  <= 1'b1;
      end

      if (take_pend) begin
        pend_v <= 1'b0;
      end else if (capture) begin
        pend   <= in_req;
        pend_v <= 1'b1;
      end

      if (state == S_DONE)                    drop <= 1'b0;
      else if (state != S_IDLE && flush_i)    drop <= 1'b1;

      // A flush on the completing cycle counts as well.
      if (state == S_R && rvalid) begin
        rdata_o   <= rdata;
        read_ok_o <= !(drop || flush_i);
      end
      if (state == S_B && bvalid) write_ok_o <= !(drop || flush_i);
    end
  end

  assign arid    = AXI_ID;
  assign araddr  = act.addr;
  assign arlen   = 8'd0;
  assign arsize  = AXI_SIZE;
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);

  assign awid    = AXI_ID;
  assign awaddr  = act.addr;
  assign awlen   = 8'd0;
  assign awsize  = AXI_SIZE;
  assign awvalid = (state == S_WR) && !aw_done;

  assign wid     = AXI_ID;
  assign wdata   = act.wdata;
  assign wstrb   = act.wen;
  assign wlast   = 1'b1;
  assign wvalid  = (state == S_WR) && !w_done;

  assign bready  = (state == S_B);

endmodule

// File: tb/tb_data_axi_bridge.sv
module tb_data_axi_bridge;

  logic        clock_i, reset_i, flush_i, ren_i;
  logic [3:0]  wen_i;
  logic [31:0] addr_i, wdata_i;
  logic        read_ok_o, write_ok_o;
  logic [31:0] rdata_o;
  logic [3:0]  arid, awid, wid;
  logic [31:0] araddr, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        awvalid, awready;
  logic [3:0]  wstrb;
  logic        wlast, wvalid, wready, bvalid, bready;

  int passed = 0;
  int total  = 0;

  data_axi_bridge dut (
    .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i), .ren_i(ren_i),
    .wen_i(wen_i), .addr_i(addr_i), .wdata_i(wdata_i),
    .read_ok_o(read_ok_o), .write_ok_o(write_ok_o), .rdata_o(rdata_o),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
    .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Read with arready/rvalid held high: AR the cycle after the sampling edge,
  // ok pulse two edges later.
  task automatic do_read(input string tag, input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] resp);
    arready = 1'b1; rvalid = 1'b1; rdata = d; rresp = resp;
    ren_i = 1'b1; addr_i = a;
    step();
    ren_i = 1'b0;
    chk({tag, "_arvalid"}, {31'd0, arvalid}, 32'd1);
    chk({tag, "_araddr"}, araddr, a);
    step();
    chk({tag, "_rready"}, {31'd0, rready}, 32'd1);
    chk({tag, "_ok_early"}, {31'd0, read_ok_o}, 32'd0);
    step();
    chk({tag, "_ok"}, {31'd0, read_ok_o}, 32'd1);
    chk({tag, "_rdata"}, rdata_o, d);
    step();
    chk({tag, "_ok_pulse"}, {31'd0, read_ok_o}, 32'd0);
    chk({tag, "_idle_ar"}, {31'd0, arvalid}, 32'd0);
    arready = 1'b0; rvalid = 1'b0;
  endtask

  initial begin
    reset_i = 1'b0; flush_i = 1'b0; ren_i = 1'b0; wen_i = 4'd0;
    addr_i = '0; wdata_i = '0;
    arready = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b1; rvalid = 1'b0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
    step(); step();

    // Reset state and constant fields
    chk("rst_valids", {26'd0, arvalid, rready, awvalid, wvalid, bready, read_ok_o}, 32'd0);
    chk("rst_wok", {31'd0, write_ok_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("const_ar", {arid, arlen, arsize}, {4'd1, 8'd0, 3'b010});
    chk("const_aw", {awid, awlen, awsize, wid, wlast}, {4'd1, 8'd0, 3'b010, 4'd1, 1'b1});
    reset_i = 1'b1;
    step();

    // Read, ready always high
    do_read("rd1", 32'h1FC0_0000, 32'hDEAD_BEEF, 2'b00);

    // Write, awready two cycles ahead of wready
    wen_i = 4'b0011; wdata_i = 32'h1234_5678; addr_i = 32'h0000_0100;
    awready = 1'b1; wready = 1'b0;
    step();
    chk("wr_aw_first", {30'd0, awvalid, wvalid}, 32'd3);
    chk("wr_wstrb", {28'd0, wstrb}, 32'h3);
    chk("wr_awaddr", awaddr, 32'h0000_0100);
    chk("wr_wdata", wdata, 32'h1234_5678);
    step();
    chk("wr_aw_dropped", {30'd0, awvalid, wvalid}, 32'd1);
    step();
    chk("wr_w_held", {30'd0, awvalid, wvalid}, 32'd1);
    wready = 1'b1;
    step();
    wready = 1'b0; awready = 1'b0;
    chk("wr_in_b", {29'd0, wvalid, bready, write_ok_o}, 32'd2);
    step();
    chk("wr_b_wait", {30'd0, bready, write_ok_o}, 32'd2);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    chk("wr_ok", {31'd0, write_ok_o}, 32'd1);
    wen_i = 4'd0;
    step();
    chk("wr_ok_pulse", {31'd0, write_ok_o}, 32'd0);
    chk("wr_no_dup", {30'd0, awvalid, wvalid}, 32'd0);
    step();
    chk("wr_no_dup2", {30'd0, awvalid, wvalid}, 32'd0);

    // Flush in AR, new read captured while draining
    ren_i = 1'b1; addr_i = 32'h0000_0040;
    step();
    ren_i = 1'b0; flush_i = 1'b1;
    step();
    flush_i = 1'b0; ren_i = 1'b1; addr_i = 32'h0000_0080;
    step();
    ren_i = 1'b0; arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h1111_1111;
    step();
    rvalid = 1'b0;
    chk("fl_ok_dropped", {31'd0, read_ok_o}, 32'd0);
    step();
    chk("fl_no_gap", {31'd0, arvalid}, 32'd1);
    chk("fl_araddr", araddr, 32'h0000_0080);
    chk("fl_ok_still0", {31'd0, read_ok_o}, 32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h2222_2222;
    step();
    rvalid = 1'b0;
    chk("fl_ok2", {31'd0, read_ok_o}, 32'd1);
    chk("fl_rdata2", rdata_o, 32'h2222_2222);
    step();
    chk("fl_ok2_pulse", {31'd0, read_ok_o}, 32'd0);
    chk("fl_idle", {31'd0, arvalid}, 32'd0);

    // Simultaneous read and write: read wins
    ren_i = 1'b1; wen_i = 4'b1111; addr_i = 32'h0000_0200;
    step();
    ren_i = 1'b0; wen_i = 4'd0;
    chk("both_ar", {29'd0, arvalid, awvalid, wvalid}, 32'd4);
    arready = 1'b1;
    step();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0033;
    step();
    rvalid = 1'b0;
    chk("both_ok", {31'd0, read_ok_o}, 32'd1);
    chk("both_rdata", rdata_o, 32'h0000_0033);
    step();

    // Reset while waiting in B
    wen_i = 4'b1111; wdata_i = 32'h0000_00AA; addr_i = 32'h0000_0300;
    awready = 1'b1; wready = 1'b1;
    step();
    step();
    awready = 1'b0; wready = 1'b0;
    chk("rb_in_b", {31'd0, bready}, 32'd1);
    reset_i = 1'b0;
    step();
    wen_i = 4'd0;
    chk("rb_valids", {25'd0, arvalid, rready, awvalid, wvalid, bready, read_ok_o, write_ok_o}, 32'd0);
    chk("rb_rdata", rdata_o, 32'd0);
    reset_i = 1'b1;
    step();
    do_read("rb_rd", 32'h0000_0400, 32'h0000_0044, 2'b00);

    // Error response still completes
    do_read("err", 32'h0000_0500, 32'hCAFE_F00D, 2'b10);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
